// File: rtl/cpu_axi_data_master.sv
// rtl/cpu_axi_data_master.sv - single-word CPU memory request to AXI4 single-beat master
module cpu_axi_data_master #(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0,
    parameter bit              WRITE_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_read,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [3:0]      req_web,
    input  logic [31:0]     req_wdata,
    input  logic            other_stall,
    output logic [31:0]     rdata,
    output logic            stall,
    output logic            bus_err,
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [7:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY,
    output logic [ID_W-1:0] AWID,
    output logic [31:0]     AWADDR,
    output logic [7:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,
    output logic [31:0]     WDATA,
    output logic [3:0]      WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        aw_done;
    logic        w_done;
    logic        r_hit;
    logic        b_hit;
    logic        issue;
    logic        unused_ok;

    // Responses carrying another master's ID are not ours to complete on.
    assign r_hit = RVALID && (RID == MASTER_ID);
    assign b_hit = BVALID && (BID == MASTER_ID);
    assign issue = req_read || (req_write && WRITE_EN);

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = 8'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign WDATA   = wdata_q;
    assign WSTRB   = strb_q;
    assign WLAST   = WRITE_EN;

    assign unused_ok = ^{RLAST, RRESP[0], BRESP[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        case (state)
            IDLE: begin
                if (req_read) begin
                    stall     = 1'b1;
                    state_nxt = RD_ADDR;
                end else if (req_write && WRITE_EN) begin
                    stall     = 1'b1;
                    state_nxt = WR_REQ;
                end
            end
            RD_ADDR: begin
                stall   = 1'b1;
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                RREADY = 1'b1;
                if (r_hit) begin
                    state_nxt = other_stall ? DONE : IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            WR_REQ: begin
                stall   = 1'b1;
                AWVALID = WRITE_EN && !aw_done;
                WVALID  = WRITE_EN && !w_done;
                if ((aw_done || AWREADY) && (w_done || WREADY)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                BREADY = WRITE_EN;
                if (b_hit) begin
                    state_nxt = other_stall ? DONE : IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            DONE: begin
                // The core is still frozen by the other port; its request is stale.
                if (!other_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            strb_q  <= 4'd0;
            rdata   <= 32'd0;
            bus_err <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (state == IDLE && issue) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                strb_q  <= ~req_web;
            end
            if (state == RD_DATA && r_hit) begin
                rdata   <= RDATA;
                bus_err <= RRESP[1];
            end
            if (state == WR_RESP && b_hit) begin
                bus_err <= BRESP[1];
            end
            if (state == WR_REQ) begin
                if (AWVALID && AWREADY) begin
                    aw_done <= 1'b1;
                end
                if (WVALID && WREADY) begin
                    w_done <= 1'b1;
                end
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_axi_data_master.sv
// tb/tb_cpu_axi_data_master.sv - bench for cpu_axi_data_master with a behavioural slave memory
module tb_cpu_axi_data_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_web = 4'hF;
    logic [31:0] req_wdata = '0;
    logic        other_stall = 1'b0;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_err;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [3:0]  RID = '0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b1;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY = 1'b0;
    logic [3:0]  BID = '0;
    logic [1:0]  BRESP = '0;
    logic        BVALID = 1'b0;
    logic        BREADY;

    logic        ro_req_write = 1'b0;
    logic [31:0] ro_rdata;
    logic        ro_stall;
    logic        ro_bus_err;
    logic [3:0]  ro_arid;
    logic [31:0] ro_araddr;
    logic [7:0]  ro_arlen;
    logic [2:0]  ro_arsize;
    logic [1:0]  ro_arburst;
    logic        ro_arvalid;
    logic        ro_rready;
    logic [3:0]  ro_awid;
    logic [31:0] ro_awaddr;
    logic [7:0]  ro_awlen;
    logic [2:0]  ro_awsize;
    logic [1:0]  ro_awburst;
    logic        ro_awvalid;
    logic [31:0] ro_wdata;
    logic [3:0]  ro_wstrb;
    logic        ro_wlast;
    logic        ro_wvalid;
    logic        ro_bready;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [int unsigned];
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    cpu_axi_data_master #(.ID_W(4), .MASTER_ID(4'h3), .WRITE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_web(req_web), .req_wdata(req_wdata),
        .other_stall(other_stall), .rdata(rdata), .stall(stall), .bus_err(bus_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    cpu_axi_data_master #(.ID_W(4), .MASTER_ID(4'h1), .WRITE_EN(1'b0)) dut_ro (
        .clk(clk), .rst(rst), .req_read(1'b0), .req_write(ro_req_write),
        .req_addr(32'h0000_3000), .req_web(4'b0000), .req_wdata(32'h1234_5678),
        .other_stall(1'b0), .rdata(ro_rdata), .stall(ro_stall), .bus_err(ro_bus_err),
        .ARID(ro_arid), .ARADDR(ro_araddr), .ARLEN(ro_arlen), .ARSIZE(ro_arsize), .ARBURST(ro_arburst),
        .ARVALID(ro_arvalid), .ARREADY(1'b0),
        .RID(4'h0), .RDATA(32'h0), .RRESP(2'b00), .RLAST(1'b0), .RVALID(1'b0), .RREADY(ro_rready),
        .AWID(ro_awid), .AWADDR(ro_awaddr), .AWLEN(ro_awlen), .AWSIZE(ro_awsize), .AWBURST(ro_awburst),
        .AWVALID(ro_awvalid), .AWREADY(1'b0),
        .WDATA(ro_wdata), .WSTRB(ro_wstrb), .WLAST(ro_wlast), .WVALID(ro_wvalid), .WREADY(1'b0),
        .BID(4'h0), .BRESP(2'b00), .BVALID(1'b0), .BREADY(ro_bready)
    );

    always @(posedge clk) begin
        if (rst && req_read && req_write) begin
            $error("illegal simultaneous read and write request from core");
        end
    end

    // Core read of one word; the slave answers from mem after ar_d/r_d wait cycles.
    task automatic do_read(input logic [31:0] a, input int ar_d, input int r_d,
                           input logic [1:0] resp, input bit bad_id, input bit keep_req);
        logic [31:0] d;
        int ar_cnt, r_cnt, stall_cnt, cyc;
        bit ar_ok, ar_ok_n, done, comp, bad_left, bad_now;
        if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
        d = mem[a[31:2]];
        req_read = 1'b1;
        req_addr = a;
        ar_cnt = 0; r_cnt = 0; stall_cnt = 0; cyc = 0;
        ar_ok = 0; ar_ok_n = 0; done = 0; comp = 0; bad_left = bad_id;
        while (!done && cyc < 200) begin
            ARREADY = 1'b0;
            RVALID  = 1'b0;
            bad_now = 0;
            if (ar_ok) begin
                if (r_cnt == r_d) begin
                    bad_now  = bad_left;
                    bad_left = 0;
                    RVALID = 1'b1;
                    RDATA  = bad_now ? ~d : d;
                    RRESP  = bad_now ? 2'b10 : resp;
                    RID    = bad_now ? 4'h5 : 4'h3;
                end else begin
                    r_cnt++;
                end
            end
            if (ARVALID) begin
                if (ar_cnt == ar_d) begin
                    ARREADY = 1'b1;
                    ar_ok_n = 1;
                    checks++;
                    if ({ARADDR, ARLEN, ARSIZE, ARBURST, ARID} !== {a, 8'd0, 3'd2, 2'd1, 4'h3}) begin
                        failures++;
                        $display("FAIL rd_ar_fields got=%h_%h_%h_%h_%h exp=%h_00_2_1_3",
                                 ARADDR, ARLEN, ARSIZE, ARBURST, ARID, a);
                    end
                end else begin
                    ar_cnt++;
                end
            end
            #1;
            if (stall) begin
                stall_cnt++;
            end else begin
                done = 1;
                comp = RVALID && RREADY && !bad_now;
            end
            @(posedge clk);
            ar_ok = ar_ok_n;
            @(negedge clk);
            cyc++;
        end
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        if (!keep_req) req_read = 1'b0;
        checks++;
        if (!comp) begin
            failures++;
            $display("FAIL rd_completion got=done%0d_cyc%0d exp=stall_release_on_rvalid", done, cyc);
        end
        checks++;
        if (stall_cnt != 2 + ar_d + r_d + int'(bad_id)) begin
            failures++;
            $display("FAIL rd_stall_cycles got=%0d exp=%0d", stall_cnt, 2 + ar_d + r_d + int'(bad_id));
        end
        exp_rdata = d;
        checks++;
        if (rdata !== exp_rdata || bus_err !== resp[1]) begin
            failures++;
            $display("FAIL rd_data_err got=%h/%b exp=%h/%b", rdata, bus_err, exp_rdata, resp[1]);
        end
        if (!keep_req) begin
            @(negedge clk);
            checks++;
            if (bus_err !== 1'b0) begin
                failures++;
                $display("FAIL rd_err_pulse got=%b exp=0", bus_err);
            end
        end
    endtask

    // Core write of one word; AW and W readies are delayed independently.
    task automatic do_write(input logic [31:0] a, input logic [3:0] web, input logic [31:0] wd,
                            input int aw_d, input int w_d, input int b_d, input logic [1:0] resp);
        logic [31:0] tmp;
        int aw_cnt, w_cnt, b_cnt, awv_cnt, wv_cnt, stall_cnt, cyc, mx;
        bit aw_ok, w_ok, aw_ok_n, w_ok_n, done, comp;
        req_write = 1'b1;
        req_addr  = a;
        req_web   = web;
        req_wdata = wd;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; awv_cnt = 0; wv_cnt = 0; stall_cnt = 0; cyc = 0;
        aw_ok = 0; w_ok = 0; aw_ok_n = 0; w_ok_n = 0; done = 0; comp = 0;
        mx = (aw_d > w_d) ? aw_d : w_d;
        while (!done && cyc < 200) begin
            AWREADY = 1'b0;
            WREADY  = 1'b0;
            BVALID  = 1'b0;
            if (aw_ok && w_ok) begin
                if (b_cnt == b_d) begin
                    BVALID = 1'b1;
                    BRESP  = resp;
                    BID    = 4'h3;
                end else begin
                    b_cnt++;
                end
            end
            if (AWVALID) begin
                awv_cnt++;
                if (aw_cnt == aw_d) begin
                    AWREADY = 1'b1;
                    aw_ok_n = 1;
                    checks++;
                    if ({AWADDR, AWLEN, AWSIZE, AWBURST, AWID} !== {a, 8'd0, 3'd2, 2'd1, 4'h3}) begin
                        failures++;
                        $display("FAIL wr_aw_fields got=%h_%h_%h_%h_%h exp=%h_00_2_1_3",
                                 AWADDR, AWLEN, AWSIZE, AWBURST, AWID, a);
                    end
                end else begin
                    aw_cnt++;
                end
            end
            if (WVALID) begin
                wv_cnt++;
                if (w_cnt == w_d) begin
                    WREADY = 1'b1;
                    w_ok_n = 1;
                    checks++;
                    if ({WDATA, WSTRB, WLAST} !== {wd, ~web, 1'b1}) begin
                        failures++;
                        $display("FAIL wr_w_fields got=%h_%b_%b exp=%h_%b_1", WDATA, WSTRB, WLAST, wd, ~web);
                    end
                end else begin
                    w_cnt++;
                end
            end
            #1;
            if (stall) begin
                stall_cnt++;
            end else begin
                done = 1;
                comp = BVALID && BREADY;
            end
            @(posedge clk);
            aw_ok = aw_ok_n;
            w_ok  = w_ok_n;
            @(negedge clk);
            cyc++;
        end
        BVALID    = 1'b0;
        req_write = 1'b0;
        if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
        tmp = mem[a[31:2]];
        for (int i = 0; i < 4; i++) begin
            if (!web[i]) tmp[8*i +: 8] = wd[8*i +: 8];
        end
        mem[a[31:2]] = tmp;
        checks++;
        if (!comp || stall_cnt != 2 + mx + b_d) begin
            failures++;
            $display("FAIL wr_stall_cycles got=%0d comp=%0d exp=%0d", stall_cnt, comp, 2 + mx + b_d);
        end
        checks++;
        if (awv_cnt != aw_d + 1 || wv_cnt != w_d + 1) begin
            failures++;
            $display("FAIL wr_valid_cycles got=aw%0d_w%0d exp=aw%0d_w%0d", awv_cnt, wv_cnt, aw_d + 1, w_d + 1);
        end
        checks++;
        if (rdata !== exp_rdata || bus_err !== resp[1]) begin
            failures++;
            $display("FAIL wr_rdata_err got=%h/%b exp=%h/%b", rdata, bus_err, exp_rdata, resp[1]);
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL wr_err_pulse got=%b exp=0", bus_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ARVALID, RREADY, AWVALID, WVALID, BREADY, stall, bus_err} !== 7'b0 || rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got=%b_%h exp=0000000_00000000",
                     {ARVALID, RREADY, AWVALID, WVALID, BREADY, stall, bus_err}, rdata);
        end
    endtask

    task automatic test_read_basic();
        mem[32'h0000_1004 >> 2] = 32'hDEAD_BEEF;
        do_read(32'h0000_1004, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_byte_write();
        do_write(32'h0000_2008, 4'b1101, 32'h0000_AB00, 3, 0, 1, 2'b00);
        do_read(32'h0000_2008, 1, 2, 2'b00, 0, 0);
    endtask

    task automatic test_other_stall();
        int arv;
        other_stall = 1'b1;
        do_read(32'h0000_1004, 0, 1, 2'b00, 0, 1);
        arv = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ARVALID || stall || rdata !== exp_rdata) arv++;
            @(negedge clk);
        end
        checks++;
        if (arv != 0) begin
            failures++;
            $display("FAIL done_hold got=%0d_bad_cycles exp=0", arv);
        end
        other_stall = 1'b0;
        req_read    = 1'b0;
        @(negedge clk);
        checks++;
        if (ARVALID !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL done_exit got=%b%b exp=00", ARVALID, stall);
        end
        do_read(32'h0000_1008, 2, 0, 2'b00, 0, 0);
    endtask

    task automatic test_error_resp();
        do_read(32'h0000_100C, 0, 0, 2'b10, 0, 0);
        do_write(32'h0000_2010, 4'b0000, 32'h5A5A_5A5A, 0, 2, 0, 2'b11);
    endtask

    task automatic test_id_mismatch();
        do_read(32'h0000_1010, 1, 1, 2'b00, 1, 0);
    endtask

    task automatic test_reset_mid_write();
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        req_write = 1'b1;
        req_addr  = 32'h0000_2020;
        req_web   = 4'b0000;
        req_wdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        checks++;
        if (AWVALID !== 1'b1 || WVALID !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b%b exp=11", AWVALID, WVALID);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (AWVALID !== 1'b0 || WVALID !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got=%b%b%b exp=000", AWVALID, WVALID, stall);
        end
        req_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_rdata = 32'd0;
        @(negedge clk);
        do_read(32'h0000_1004, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_write_disabled();
        int bad;
        bad = 0;
        ro_req_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ro_awvalid || ro_wvalid || ro_bready || ro_stall) bad++;
        end
        ro_req_write = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ro_write_ignored got=%0d_active_cycles exp=0", bad);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            a = 32'h0000_4000 + ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 3) == 0), 0);
            end else begin
                do_write(a, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), 2'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read_basic();
        test_byte_write();
        test_other_stall();
        test_error_resp();
        test_id_mismatch();
        test_reset_mid_write();
        test_write_disabled();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_axi_data_master.md
Name: cpu_axi_data_master

Overview:
- Downstream neighbour of the CPU core's MEM stage.
- Converts the core's single-word SRAM-style data request (EXE_MemRead / EXE_MemWrite, address, WEB, DI) into one AXI4 single-beat transaction.
- Returns read data (DO) and generates DM_stall to freeze the pipeline until the transaction completes.
- One instance per master port; the instruction-side port uses a read-only strap of the same block (WRITE_EN=0).

Parameters:
- ID_W, 4, width of AXI ID fields.
- MASTER_ID, 0, constant driven on ARID/AWID.
- WRITE_EN, 1, 0 ties off AW/W/B channels and ignores write requests.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_read  in  1  CPU read request (EXE_MemRead).
- req_write  in  1  CPU write request (EXE_MemWrite).
- req_addr  in  32  byte address (EXE_ALU_out).
- req_web  in  4  active-low byte write enables; 4'b1111 = no byte written.
- req_wdata  in  32  write data (DI).
- other_stall  in  1  stall from the other memory port (IM_stall for the data instance).
- rdata  out  32  read data to the core (DO).
- stall  out  1  DM_stall to the core.
- bus_err  out  1  one-cycle pulse on a SLVERR/DECERR response.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out; ARREADY  in.
- RID/RDATA/RRESP/RLAST/RVALID  in; RREADY  out.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out; AWREADY  in.
- WDATA/WSTRB/WLAST/WVALID  out; WREADY  in.
- BID/BRESP/BVALID  in; BREADY  out.

Behaviour:
- Reset values (rst=0, effective immediately):
  - state=IDLE.
  - All VALID/READY outputs=0.
  - rdata=0, bus_err=0, internal aw_done/w_done=0.
- Constant AXI fields:
  - LEN=0, SIZE=3'b010, BURST=2'b01.
  - WLAST=1.
  - WSTRB=~req_web, captured at issue.
  - ID=MASTER_ID.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - If req_read: stall=1 combinationally in the same cycle; capture addr; go to RD_ADDR with ARVALID=1 from the next cycle.
  - Else if req_write and WRITE_EN: capture addr, wdata, strb; go to WR_REQ with AWVALID=WVALID=1.
  - If both read and write are set, read wins. This is illegal from the core; a bench assertion flags it.
  - With no request, stall=0.
- RD_ADDR:
  - Hold ARVALID and ARADDR stable until ARREADY.
  - On handshake, ARVALID=0 in the next cycle; go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID, latch RDATA into rdata; stall=0 that cycle (completion cycle).
  - If RRESP[1]=1, pulse bus_err.
  - Next state is DONE if other_stall=1, else IDLE.
- WR_REQ:
  - AW and W are issued in parallel; each VALID drops independently after its own handshake (tracked by aw_done/w_done).
  - Both handshakes may occur in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID, stall=0; pulse bus_err if BRESP[1].
  - Next state is DONE if other_stall, else IDLE.
- DONE:
  - stall=0; rdata held.
  - Stay while other_stall=1. This stops the still-frozen request from being reissued.
  - Return to IDLE on the first cycle other_stall=0.
  - Requests are ignored in DONE.
- Latency: minimum 3 cycles, request to completion, with zero-wait slaves (issue cycle, address handshake, data/response).
- rdata changes only at a read completion. Write completion leaves rdata unchanged.
- Responses whose RID/BID mismatch MASTER_ID are ignored (not accepted as completion).
- Reset asserted mid-transaction:
  - Immediate return to IDLE; VALIDs drop asynchronously.
  - The outstanding bus transaction is abandoned; the system reset also resets the slaves.

Test Plan:
- Read, zero-wait slave: req_read=1, addr=0x0000_1004, RDATA=0xDEAD_BEEF → ARADDR=0x1004, ARLEN=0, ARSIZE=2; stall high 2 cycles, low in the RVALID cycle; rdata=0xDEADBEEF.
- Byte write: req_write=1, req_web=4'b1101, wdata=0x0000_AB00, AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID after 4, WSTRB=4'b0010; stall released on BVALID.
- Other stall held: read completes while other_stall=1 for 5 cycles with req_read still high → exactly one AR issued; FSM in DONE; stall=0; rdata stable; IDLE after other_stall falls.
- Error response: RRESP=2'b10 → bus_err pulses 1 cycle; rdata=RDATA; stall released normally.
- Reset mid-write: drop rst while AWVALID=1 → AWVALID/WVALID=0 immediately, stall=0, state IDLE; a new read after rst=1 completes correctly.
- WRITE_EN=0: req_write=1 → no AW/W activity, stall=0, AWVALID/WVALID/BREADY stay 0.
